adc_pulse_emulator: RTL and testbench
=====================================

Name: adc_pulse_emulator

Overview:
Synthesizable AXI4-Stream master that emulates the RF Data Converter ADC stream feeding the minimum trigger. It emits 128-bit beats of 8 packed 12-bit samples: a baseline with even/odd alternating noise, followed by repeating two-step pulse sets (tall first peak, lower second peak). It is used for on-board self-test of the trigger/DMA chain without an analog source, and provides a pulse marker as ground truth for checking trigger timing.

Parameters:
ADC_RESOLUTION_WIDTH, 12, sample width; sample occupies bits [16*k +: ADC_RESOLUTION_WIDTH] of slot k, remaining slot bits 0
M_AXIS_TDATA_WIDTH, 128, stream width; SAMPLE_PER_TDATA = M_AXIS_TDATA_WIDTH/16 (8)
LEN_WIDTH, 16, width of phase-length and count inputs

Ports:
AXIS_ACLK  in  1  clock
AXIS_ARESETN  in  1  reset, asynchronous, active-low
I_ENABLE  in  1  run request (level)
I_BL_EVEN  in  ADC_RESOLUTION_WIDTH  baseline value for even slots
I_BL_ODD  in  ADC_RESOLUTION_WIDTH  baseline value for odd slots
I_FST_HEIGHT  in  ADC_RESOLUTION_WIDTH  first peak height above baseline
I_SND_HEIGHT  in  ADC_RESOLUTION_WIDTH  second peak height above baseline
I_PRE_LEN, I_FST_LEN, I_SND_LEN, I_POST_LEN  in  LEN_WIDTH each  phase lengths in beats
I_NUM_SETS  in  LEN_WIDTH  pulse sets per run; 0 = unlimited
M_AXIS_TDATA  out  M_AXIS_TDATA_WIDTH  sample beat
M_AXIS_TVALID  out  1  beat valid
M_AXIS_TREADY  in  1  sink ready
O_PULSE_MARK  out  1  high on the beat carrying the first FST sample of a set
O_SET_CNT  out  LEN_WIDTH  completed pulse sets in the current run
O_BUSY  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, immediate, including mid-beat): state IDLE, TDATA=0, TVALID=0, O_PULSE_MARK=0, O_SET_CNT=0, O_BUSY=0. Any in-flight beat is dropped.
- All outputs are registered. Handshake = TVALID & TREADY. TDATA and O_PULSE_MARK are held stable while TVALID=1 and TREADY=0. TVALID never deasserts without a handshake, except on reset.
- Phase lengths count accepted beats, not clock cycles.
- States: IDLE, PRE, FST, SND, POST, DONE.
- IDLE, I_ENABLE=1 sampled at edge k: latch all I_* config, clear O_SET_CNT, enter the first phase with nonzero length. At edge k+1: TVALID=1 and the first beat is presented.
- Beat content per phase, per slot k (even/odd = parity of k):
  - PRE, POST: BL.
  - FST: BL + FST_HEIGHT.
  - SND: BL + SND_HEIGHT.
  - Sums are computed in ADC_RESOLUTION_WIDTH+1 bits and saturate at 2^ADC_RESOLUTION_WIDTH-1.
- Phase transitions occur on the handshake of a phase's last beat: PRE -> FST -> SND -> POST, skipping any phase with length 0. The next beat is registered so that there is no TVALID bubble.
- All four lengths = 0: a set is one baseline beat.
- Handshake of the last beat of a set:
  - O_SET_CNT increments (wraps at 2^LEN_WIDTH).
  - If I_ENABLE=1 and (NUM_SETS=0 or new count < NUM_SETS): re-latch config and start the next set, back-to-back.
  - Else if the count was reached: enter DONE with TVALID=0.
  - Else (I_ENABLE=0): enter IDLE with TVALID=0.
- I_ENABLE dropping mid-set: the current set finishes fully. No truncation.
- DONE: TVALID=0, O_BUSY=1, O_SET_CNT held; go to IDLE when I_ENABLE=0.
- Config changes mid-set are ignored until the next latch point.
- O_PULSE_MARK=1 only on the first FST beat. If FST_LEN=0, it is on the first SND beat; if both are 0, it is never asserted.

Test Plan:
- Basic set: BL 10/12, FST_H 3276, SND_H 409, lengths 10/10/20/10, NUM_SETS 1, TREADY=1 -> 50 beats. PRE beats: even slots 0x00A, odd slots 0x00C. FST beats: 0xCD6/0xCD8. SND beats: 0x1A3/0x1A5. O_PULSE_MARK on beat 11 only. Then DONE, O_SET_CNT=1, TVALID=0.
- Backpressure: same config, TREADY random 50% -> identical 50-beat sequence; TDATA stable during every stall; total accepted beats = 50.
- Saturation: BL 4000/4090, FST_H 200 -> FST slots all 0xFFF; upper 4 bits of each slot are 0.
- Continuous run: NUM_SETS 0, I_ENABLE held for 3 sets then dropped during the third set's SND phase -> third set completes, TVALID drops, O_SET_CNT=3, IDLE.
- Zero lengths: FST_LEN 0 -> O_PULSE_MARK on the first SND beat. All lengths 0, NUM_SETS 4 -> exactly 4 baseline beats.
- Async reset asserted mid-FST with TREADY=0 -> TVALID=0, TDATA=0 immediately, before the next clock edge. Restart after release -> first beat is PRE.

Source files
------------

// File: rtl/adc_pulse_emulator_if.sv
// AXI4-Stream beat channel of the ADC pulse emulator.
// Carries tdata/tvalid/tready and the pulse marker that accompanies each beat.
interface adc_pulse_emulator_if #(
  parameter int DW = 128
) ();
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY;
  logic          O_PULSE_MARK;

  modport master (
    output M_AXIS_TDATA,
    output M_AXIS_TVALID,
    output O_PULSE_MARK,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TDATA,
    input  M_AXIS_TVALID,
    input  O_PULSE_MARK,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/adc_pulse_emulator.sv
// Emits baseline + two-step pulse sets as 8x12-bit AXIS beats for self-test.
// Ports: clk/async reset, I_* config, m_axis stream, O_SET_CNT, O_BUSY.
module adc_pulse_emulator #(
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int M_AXIS_TDATA_WIDTH   = 128,
  parameter int LEN_WIDTH            = 16
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic                            I_ENABLE,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] I_BL_EVEN,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] I_BL_ODD,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] I_FST_HEIGHT,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] I_SND_HEIGHT,
  input  logic [LEN_WIDTH-1:0]            I_PRE_LEN,
  input  logic [LEN_WIDTH-1:0]            I_FST_LEN,
  input  logic [LEN_WIDTH-1:0]            I_SND_LEN,
  input  logic [LEN_WIDTH-1:0]            I_POST_LEN,
  input  logic [LEN_WIDTH-1:0]            I_NUM_SETS,
  adc_pulse_emulator_if.master            m_axis,
  output logic [LEN_WIDTH-1:0]            O_SET_CNT,
  output logic                            O_BUSY
);
  localparam int AW  = ADC_RESOLUTION_WIDTH;
  localparam int DW  = M_AXIS_TDATA_WIDTH;
  localparam int LW  = LEN_WIDTH;
  localparam int SPT = DW / 16;
  localparam logic [LW-1:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE, PRE, FST, SND, POST, DONE
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_cnt;
  logic [DW-1:0]   r_tdata;
  logic            r_tvalid;
  logic            r_mark;
  logic            r_busy;
  logic [LW-1:0]   r_set_cnt;
  logic [AW-1:0]   r_bl_even, r_bl_odd;
  logic [AW-1:0]   r_fst_h, r_snd_h;
  logic [LW-1:0]   r_pre_len, r_fst_len;
  logic [LW-1:0]   r_snd_len, r_post_len;
  logic [LW-1:0]   r_num_sets;

  state_t          w_nstate, w_first_in;
  state_t          w_after_pre, w_after_cur;
  logic [LW-1:0]   w_ncnt, w_nset, w_set_inc;
  logic [LW-1:0]   w_len_cur;
  logic            w_nvalid, w_load, w_latch;
  logic            w_hs, w_last, w_mark;
  logic [DW-1:0]   w_beat;
  logic [AW-1:0]   w_bl_even, w_bl_odd;
  logic [AW-1:0]   w_fst_h, w_snd_h;
  logic [LW-1:0]   w_fst_len;

  // Next nonzero phase after s; IDLE means the set is over.
  function automatic state_t after_phase(
    state_t s, logic fz, logic sz, logic pz
  );
    after_phase = IDLE;
    if (s == PRE && fz)
      after_phase = FST;
    else if ((s == PRE || s == FST) && sz)
      after_phase = SND;
    else if (s != POST && pz)
      after_phase = POST;
  endfunction

  function automatic logic [DW-1:0] make_beat(
    state_t s,
    logic [AW-1:0] e, logic [AW-1:0] o,
    logic [AW-1:0] fh, logic [AW-1:0] sh
  );
    logic [AW-1:0] h;
    logic [AW:0]   sum;
    make_beat = '0;
    h = (s == FST) ? fh : (s == SND) ? sh : '0;
    for (int k = 0; k < SPT; k++) begin
      sum = {1'b0, k[0] ? o : e} + {1'b0, h};
      make_beat[16*k +: AW] =
        sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
    end
  endfunction

  assign w_hs      = r_tvalid & m_axis.M_AXIS_TREADY;
  assign w_set_inc = r_set_cnt + ONE;

  // A set whose lengths are all zero still emits one PRE baseline beat.
  assign w_after_pre = after_phase(PRE, |I_FST_LEN,
                                   |I_SND_LEN, |I_POST_LEN);
  assign w_first_in  = (|I_PRE_LEN || w_after_pre == IDLE)
                     ? PRE : w_after_pre;
  assign w_after_cur = after_phase(r_state, |r_fst_len,
                                   |r_snd_len, |r_post_len);

  always_comb begin
    w_len_cur = '0;
    unique case (r_state)
      PRE:     w_len_cur = r_pre_len;
      FST:     w_len_cur = r_fst_len;
      SND:     w_len_cur = r_snd_len;
      POST:    w_len_cur = r_post_len;
      default: w_len_cur = '0;
    endcase
  end

  // Zero length (only seen in the all-zero PRE) is a one-beat phase.
  assign w_last = ({1'b0, r_cnt} + {1'b0, ONE})
               >= {1'b0, w_len_cur};

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nvalid = r_tvalid;
    w_nset   = r_set_cnt;
    w_load   = 1'b0;
    w_latch  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (I_ENABLE) begin
          w_latch  = 1'b1;
          w_load   = 1'b1;
          w_nvalid = 1'b1;
          w_nset   = '0;
          w_ncnt   = '0;
          w_nstate = w_first_in;
        end
      end
      PRE, FST, SND, POST: begin
        if (w_hs) begin
          w_load = 1'b1;
          if (!w_last) begin
            w_ncnt = r_cnt + ONE;
          end else begin
            w_ncnt = '0;
            if (w_after_cur != IDLE) begin
              w_nstate = w_after_cur;
            end else begin
              w_nset = w_set_inc;
              if (I_ENABLE && (r_num_sets == '0 ||
                  w_set_inc < r_num_sets)) begin
                w_latch  = 1'b1;
                w_nstate = w_first_in;
              end else begin
                w_load   = 1'b0;
                w_nvalid = 1'b0;
                w_nstate = (r_num_sets != '0 &&
                            w_set_inc >= r_num_sets)
                         ? DONE : IDLE;
              end
            end
          end
        end
      end
      DONE: begin
        if (!I_ENABLE)
          w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  // Config view for the beat being built: fresh inputs at a latch point.
  assign w_bl_even = w_latch ? I_BL_EVEN    : r_bl_even;
  assign w_bl_odd  = w_latch ? I_BL_ODD     : r_bl_odd;
  assign w_fst_h   = w_latch ? I_FST_HEIGHT : r_fst_h;
  assign w_snd_h   = w_latch ? I_SND_HEIGHT : r_snd_h;
  assign w_fst_len = w_latch ? I_FST_LEN    : r_fst_len;

  assign w_beat = make_beat(w_nstate, w_bl_even, w_bl_odd,
                            w_fst_h, w_snd_h);
  assign w_mark = (w_ncnt == '0) &&
                  (w_nstate == FST ||
                   (w_nstate == SND && w_fst_len == '0));

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_mark     <= 1'b0;
      r_busy     <= 1'b0;
      r_set_cnt  <= '0;
      r_bl_even  <= '0;
      r_bl_odd   <= '0;
      r_fst_h    <= '0;
      r_snd_h    <= '0;
      r_pre_len  <= '0;
      r_fst_len  <= '0;
      r_snd_len  <= '0;
      r_post_len <= '0;
      r_num_sets <= '0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_tvalid  <= w_nvalid;
      r_set_cnt <= w_nset;
      r_busy    <= (w_nstate != IDLE);
      if (w_load) begin
        r_tdata <= w_beat;
        r_mark  <= w_mark;
      end else if (!w_nvalid) begin
        r_mark  <= 1'b0;
      end
      if (w_latch) begin
        r_bl_even  <= I_BL_EVEN;
        r_bl_odd   <= I_BL_ODD;
        r_fst_h    <= I_FST_HEIGHT;
        r_snd_h    <= I_SND_HEIGHT;
        r_pre_len  <= I_PRE_LEN;
        r_fst_len  <= I_FST_LEN;
        r_snd_len  <= I_SND_LEN;
        r_post_len <= I_POST_LEN;
        r_num_sets <= I_NUM_SETS;
      end
    end
  end

  assign m_axis.M_AXIS_TDATA  = r_tdata;
  assign m_axis.M_AXIS_TVALID = r_tvalid;
  assign m_axis.O_PULSE_MARK  = r_mark;
  assign O_SET_CNT            = r_set_cnt;
  assign O_BUSY               = r_busy;
endmodule

// File: tb/tb_adc_pulse_emulator.sv
// Scoreboard bench for adc_pulse_emulator: model-built beat queue vs DUT.
// Ports: drives clk/reset, config, tready; monitors stream and status.
module tb_adc_pulse_emulator;
  localparam int AW = 12;
  localparam int DW = 128;
  localparam int LW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          m;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] bl_e = '0, bl_o = '0, fh = '0, sh = '0;
  logic [LW-1:0] pre_l = '0, fst_l = '0, snd_l = '0;
  logic [LW-1:0] post_l = '0, num_s = '0;
  logic [LW-1:0] set_cnt;
  logic          busy;
  logic          tready = 1'b0;
  logic          tready_fix = 1'b0;
  logic          rand_mode = 1'b0;

  beat_t         exp_q[$];
  beat_t         eb;
  int            checks = 0;
  int            failures = 0;
  int            hs_cnt = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_d;
  logic          prev_m;

  always #5 clk = ~clk;

  adc_pulse_emulator_if #(.DW(DW)) axis ();
  assign axis.M_AXIS_TREADY = tready;

  adc_pulse_emulator dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .I_ENABLE     (en),
    .I_BL_EVEN    (bl_e),
    .I_BL_ODD     (bl_o),
    .I_FST_HEIGHT (fh),
    .I_SND_HEIGHT (sh),
    .I_PRE_LEN    (pre_l),
    .I_FST_LEN    (fst_l),
    .I_SND_LEN    (snd_l),
    .I_POST_LEN   (post_l),
    .I_NUM_SETS   (num_s),
    .m_axis       (axis),
    .O_SET_CNT    (set_cnt),
    .O_BUSY       (busy)
  );

  // Sink: tready changes just after the rising edge only.
  always @(posedge clk) begin
    #1;
    tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_fix;
  end

  function automatic logic [DW-1:0] model_beat(int e, int o, int h);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < DW / 16; k++) begin
      int v;
      v = ((k % 2) ? o : e) + h;
      if (v > 4095) v = 4095;
      r[16*k +: 16] = 16'(v);
    end
    return r;
  endfunction

  task automatic push_sets(input int n);
    beat_t b;
    for (int s = 0; s < n; s++) begin
      if (pre_l == 0 && fst_l == 0 && snd_l == 0 && post_l == 0) begin
        b.d = model_beat(bl_e, bl_o, 0); b.m = 1'b0;
        exp_q.push_back(b);
      end else begin
        for (int i = 0; i < pre_l; i++) begin
          b.d = model_beat(bl_e, bl_o, 0); b.m = 1'b0;
          exp_q.push_back(b);
        end
        for (int i = 0; i < fst_l; i++) begin
          b.d = model_beat(bl_e, bl_o, fh); b.m = (i == 0);
          exp_q.push_back(b);
        end
        for (int i = 0; i < snd_l; i++) begin
          b.d = model_beat(bl_e, bl_o, sh);
          b.m = (i == 0) && (fst_l == 0);
          exp_q.push_back(b);
        end
        for (int i = 0; i < post_l; i++) begin
          b.d = model_beat(bl_e, bl_o, 0); b.m = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!axis.M_AXIS_TVALID || axis.M_AXIS_TDATA !== prev_d ||
            axis.O_PULSE_MARK !== prev_m) begin
          failures++;
          $display("FAIL stall_hold: got v=%b d=%h m=%b want v=1 d=%h m=%b",
                   axis.M_AXIS_TVALID, axis.M_AXIS_TDATA,
                   axis.O_PULSE_MARK, prev_d, prev_m);
        end
      end
      if (axis.M_AXIS_TVALID && tready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got d=%h m=%b, queue empty",
                   axis.M_AXIS_TDATA, axis.O_PULSE_MARK);
        end else begin
          eb = exp_q.pop_front();
          if (axis.M_AXIS_TDATA !== eb.d || axis.O_PULSE_MARK !== eb.m) begin
            failures++;
            $display("FAIL beat_%0d: got d=%h m=%b want d=%h m=%b",
                     hs_cnt, axis.M_AXIS_TDATA, axis.O_PULSE_MARK,
                     eb.d, eb.m);
          end
        end
      end
      prev_stall = axis.M_AXIS_TVALID && !tready;
      prev_d = axis.M_AXIS_TDATA;
      prev_m = axis.O_PULSE_MARK;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // kind 0: DONE (busy, no valid); 1: idle; 2: hs_cnt >= target
  task automatic wait_for(input int kind, input int target,
                          input int limit, input string name);
    bit ok = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if ((kind == 0 && busy && !axis.M_AXIS_TVALID) ||
          (kind == 1 && !busy) ||
          (kind == 2 && hs_cnt >= target)) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: timeout after %0d cycles", name, limit);
    end
  endtask

  task automatic start();
    @(posedge clk); #1;
    en = 1'b1;
  endtask

  task automatic stop_and_idle(input string name);
    @(posedge clk); #1;
    en = 1'b0;
    wait_for(1, 0, 50, name);
  endtask

  task automatic set_cfg(input int e, input int o, input int f,
                         input int s, input int p0, input int p1,
                         input int p2, input int p3, input int n);
    bl_e = AW'(e); bl_o = AW'(o); fh = AW'(f); sh = AW'(s);
    pre_l = LW'(p0); fst_l = LW'(p1); snd_l = LW'(p2);
    post_l = LW'(p3); num_s = LW'(n);
  endtask

  task automatic run_to_done(input int nsets, input int nbeats,
                             input string name);
    int hs0;
    hs0 = hs_cnt;
    push_sets(nsets);
    start();
    wait_for(0, 0, 4000, {name, "_done"});
    chk({name, "_setcnt"}, DW'(set_cnt), DW'(nsets));
    chk({name, "_beats"}, DW'(hs_cnt - hs0), DW'(nbeats));
    chk({name, "_qempty"}, DW'(exp_q.size()), '0);
    stop_and_idle({name, "_idle"});
  endtask

  initial begin
    int hs0;
    int ns;
    #1;
    chk("rst_tvalid", DW'(axis.M_AXIS_TVALID), '0);
    chk("rst_tdata", axis.M_AXIS_TDATA, '0);
    chk("rst_mark", DW'(axis.O_PULSE_MARK), '0);
    chk("rst_setcnt", DW'(set_cnt), '0);
    chk("rst_busy", DW'(busy), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic set, sink always ready
    set_cfg(10, 12, 3276, 409, 10, 10, 20, 10, 1);
    rand_mode = 0; tready_fix = 1;
    hs0 = hs_cnt;
    push_sets(1);
    start();
    wait_for(0, 0, 500, "basic_done");
    chk("basic_setcnt", DW'(set_cnt), 1);
    chk("basic_tvalid", DW'(axis.M_AXIS_TVALID), '0);
    chk("basic_busy_done", DW'(busy), 1);
    chk("basic_beats", DW'(hs_cnt - hs0), 50);
    stop_and_idle("basic_idle");
    chk("basic_busy_idle", DW'(busy), '0);

    // backpressure, config scrambled after latch must be ignored
    set_cfg(10, 12, 3276, 409, 10, 10, 20, 10, 1);
    rand_mode = 1;
    hs0 = hs_cnt;
    push_sets(1);
    start();
    @(posedge clk); #1;
    set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095), $urandom_range(0, 4095),
            3, 3, 3, 3, 5);
    wait_for(0, 0, 2000, "bp_done");
    chk("bp_setcnt", DW'(set_cnt), 1);
    chk("bp_beats", DW'(hs_cnt - hs0), 50);
    stop_and_idle("bp_idle");

    // saturation
    set_cfg(4000, 4090, 200, $urandom_range(0, 4095),
            $urandom_range(1, 4), $urandom_range(1, 4),
            $urandom_range(1, 4), $urandom_range(1, 4), 1);
    run_to_done(1, pre_l + fst_l + snd_l + post_l, "sat");

    // continuous run, enable dropped in third set's SND phase
    set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095), $urandom_range(0, 4095),
            3, 4, 5, 3, 0);
    hs0 = hs_cnt;
    push_sets(3);
    start();
    wait_for(2, hs0 + 38, 2000, "cont_snd3");
    @(posedge clk); #1;
    en = 1'b0;
    wait_for(1, 0, 2000, "cont_idle");
    chk("cont_setcnt", DW'(set_cnt), 3);
    chk("cont_tvalid", DW'(axis.M_AXIS_TVALID), '0);
    chk("cont_beats", DW'(hs_cnt - hs0), 45);
    chk("cont_qempty", DW'(exp_q.size()), '0);

    // FST length zero: marker on first SND beat
    set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095), $urandom_range(0, 4095),
            2, 0, 3, 1, 2);
    run_to_done(2, 12, "nofst");

    // all lengths zero: one baseline beat per set
    set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095), $urandom_range(0, 4095),
            0, 0, 0, 0, 4);
    rand_mode = 0; tready_fix = 1;
    run_to_done(4, 4, "zero");

    // randomized configurations
    rand_mode = 1;
    for (int t = 0; t < 6; t++) begin
      ns = $urandom_range(1, 3);
      set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095),
              $urandom_range(0, 4095), $urandom_range(0, 4095),
              $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4), ns);
      if (pre_l + fst_l + snd_l + post_l == 0)
        run_to_done(ns, ns, "rnd");
      else
        run_to_done(ns, ns * (pre_l + fst_l + snd_l + post_l), "rnd");
    end

    // async reset mid-FST while stalled
    rand_mode = 0; tready_fix = 1;
    set_cfg(100, 200, 300, 400, 2, 5, 2, 2, 1);
    hs0 = hs_cnt;
    push_sets(1);
    start();
    wait_for(2, hs0 + 3, 200, "rst_fst");
    tready_fix = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", DW'(axis.M_AXIS_TVALID), '0);
    chk("arst_tdata", axis.M_AXIS_TDATA, '0);
    chk("arst_mark", DW'(axis.O_PULSE_MARK), '0);
    chk("arst_busy", DW'(busy), '0);
    exp_q.delete();
    en = 1'b0;
    tready_fix = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_cfg(7, 9, 1000, 500, 3, 2, 2, 1, 1);
    run_to_done(1, 8, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
